// File: rtl/sw_cell_pipe.sv
// Two-stage pipelined alignment scoring cell with saturating arithmetic, local-mode
// zero-clamp, valid/ready flow control and a running best-score tracker.
module sw_cell_pipe #(
  parameter int SCORE_W = 8,
  parameter int CHAR_W  = 2,
  parameter int IDX_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHAR_W-1:0]         a_char,
  input  logic [CHAR_W-1:0]         b_char,
  input  logic signed [SCORE_W-1:0] score_diag,
  input  logic signed [SCORE_W-1:0] score_up,
  input  logic signed [SCORE_W-1:0] score_left,
  input  logic signed [SCORE_W-1:0] match_score,
  input  logic signed [SCORE_W-1:0] mismatch_score,
  input  logic signed [SCORE_W-1:0] gap_penalty,
  input  logic                      local_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [SCORE_W-1:0] score,
  output logic [1:0]                direction,
  input  logic                      best_clear,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [IDX_W-1:0]          best_idx
);

  localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] S_MAX = {1'b0, {(SCORE_W-1){1'b1}}};

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_STOP = 2'b11;

  function automatic logic signed [SCORE_W:0] sext(input logic signed [SCORE_W-1:0] v);
    return {v[SCORE_W-1], v};
  endfunction

  // Overflow in the widened sum shows up as the top two bits disagreeing.
  function automatic logic signed [SCORE_W-1:0] sat(input logic signed [SCORE_W:0] x);
    if (x[SCORE_W] != x[SCORE_W-1])
      return x[SCORE_W] ? S_MIN : S_MAX;
    else
      return x[SCORE_W-1:0];
  endfunction

  logic                      vld_p1, vld_p2;
  logic signed [SCORE_W-1:0] cd_p1, cu_p1, cl_p1;
  logic                      local_p1;
  logic signed [SCORE_W-1:0] score_p2;
  logic [1:0]                dir_p2;

  logic                      load_p2, free_p1, accept, xfer;
  logic signed [SCORE_W-1:0] sub_s;
  logic signed [SCORE_W:0]   cd_w, cu_w, cl_w;
  logic signed [SCORE_W-1:0] sel_s;
  logic [1:0]                sel_d;

  logic [IDX_W-1:0]          cnt;
  logic signed [SCORE_W-1:0] best_q;
  logic [IDX_W-1:0]          idx_q;

  assign load_p2  = !vld_p2 || out_ready;
  assign free_p1  = !vld_p1 || load_p2;
  assign in_ready = !rst && free_p1;
  assign accept   = in_valid && in_ready;
  assign xfer     = vld_p2 && out_ready;

  always_comb begin
    sub_s = (a_char == b_char) ? match_score : mismatch_score;
    cd_w  = sext(score_diag) + sext(sub_s);
    cu_w  = sext(score_up) + sext(gap_penalty);
    cl_w  = sext(score_left) + sext(gap_penalty);
  end

  // Stage 1: saturated candidates
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (free_p1)
      vld_p1 <= in_valid;
    if (accept) begin
      cd_p1    <= sat(cd_w);
      cu_p1    <= sat(cu_w);
      cl_p1    <= sat(cl_w);
      local_p1 <= local_mode;
    end
  end

  // Strict compares keep the earlier candidate on ties: diag > up > left.
  always_comb begin
    sel_s = cd_p1;
    sel_d = DIR_DIAG;
    if (cu_p1 > sel_s) begin
      sel_s = cu_p1;
      sel_d = DIR_UP;
    end
    if (cl_p1 > sel_s) begin
      sel_s = cl_p1;
      sel_d = DIR_LEFT;
    end
    if (local_p1 && (sel_s < 0)) begin
      sel_s = '0;
      sel_d = DIR_STOP;
    end
  end

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      score_p2 <= '0;
      dir_p2   <= DIR_DIAG;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        score_p2 <= sel_s;
        dir_p2   <= sel_d;
      end
    end
  end

  assign out_valid = vld_p2;
  assign score     = score_p2;
  assign direction = dir_p2;

  // Best tracker: a clear coinciding with a transfer restarts on that cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      best_q <= S_MIN;
      idx_q  <= '0;
    end else if (best_clear) begin
      idx_q <= '0;
      if (xfer) begin
        best_q <= score_p2;
        cnt    <= IDX_W'(1);
      end else begin
        best_q <= S_MIN;
        cnt    <= '0;
      end
    end else if (xfer) begin
      cnt <= cnt + IDX_W'(1);
      if (score_p2 > best_q) begin
        best_q <= score_p2;
        idx_q  <= cnt;
      end
    end
  end

  assign best_score = best_q;
  assign best_idx   = idx_q;

endmodule

// File: tb/tb_sw_cell_pipe.sv
// Randomized and directed bench for sw_cell_pipe against a queue-based behavioural model.
module tb_sw_cell_pipe;

  localparam int SCORE_W = 8;
  localparam int CHAR_W  = 2;
  localparam int IDX_W   = 16;
  localparam int S_MIN   = -(1 << (SCORE_W-1));
  localparam int S_MAX   = (1 << (SCORE_W-1)) - 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [CHAR_W-1:0]         a_char = '0, b_char = '0;
  logic signed [SCORE_W-1:0] score_diag = '0, score_up = '0, score_left = '0;
  logic signed [SCORE_W-1:0] match_score = '0, mismatch_score = '0, gap_penalty = '0;
  logic                      local_mode = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic signed [SCORE_W-1:0] score;
  logic [1:0]                direction;
  logic                      best_clear = 1'b0;
  logic signed [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]          best_idx;

  sw_cell_pipe #(.SCORE_W(SCORE_W), .CHAR_W(CHAR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_char(a_char), .b_char(b_char),
    .score_diag(score_diag), .score_up(score_up), .score_left(score_left),
    .match_score(match_score), .mismatch_score(mismatch_score), .gap_penalty(gap_penalty),
    .local_mode(local_mode), .out_valid(out_valid), .out_ready(out_ready),
    .score(score), .direction(direction), .best_clear(best_clear),
    .best_score(best_score), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference cell: plain integer arithmetic from the scoring rules.
  typedef struct { int s; int d; } exp_t;
  exp_t q[$];

  function automatic int clampw(input int x);
    if (x > S_MAX) return S_MAX;
    if (x < S_MIN) return S_MIN;
    return x;
  endfunction

  function automatic exp_t ref_cell(input int a, input int b, input int d, input int u,
                                    input int l, input int m, input int mm, input int g,
                                    input bit loc);
    exp_t r;
    int cd, cu, cl, mx;
    cd = clampw(d + ((a == b) ? m : mm));
    cu = clampw(u + g);
    cl = clampw(l + g);
    mx = cd;
    if (cu > mx) mx = cu;
    if (cl > mx) mx = cl;
    r.s = mx;
    r.d = (cd == mx) ? 0 : (cu == mx) ? 1 : 2;
    if (loc && mx < 0) begin
      r.s = 0;
      r.d = 3;
    end
    return r;
  endfunction

  // Monitor: on the falling edge, predict what the next rising edge will do.
  bit       started = 0;
  int       m_best = S_MIN;
  int       m_idx = 0;
  int       m_cnt = 0;
  exp_t     cur;

  always @(negedge clk) begin
    if (started) begin
      chk("best_score", int'(best_score), m_best);
      chk("best_idx", int'(best_idx), m_idx);
      if (out_valid) begin
        if (q.size() == 0)
          chk("unexpected_out", int'(out_valid), 0);
        else begin
          chk("score", int'(score), q[0].s);
          chk("direction", int'(direction), q[0].d);
        end
      end
      if (rst) begin
        q.delete();
        m_best = S_MIN;
        m_idx  = 0;
        m_cnt  = 0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          cur = q.pop_front();
          if (best_clear) begin
            m_best = cur.s;
            m_idx  = 0;
            m_cnt  = 1;
          end else begin
            if (cur.s > m_best) begin
              m_best = cur.s;
              m_idx  = m_cnt;
            end
            m_cnt = (m_cnt + 1) % (1 << IDX_W);
          end
        end else if (best_clear) begin
          m_best = S_MIN;
          m_idx  = 0;
          m_cnt  = 0;
        end
        if (in_valid && in_ready)
          q.push_back(ref_cell(int'(a_char), int'(b_char), int'(score_diag), int'(score_up),
                               int'(score_left), int'(match_score), int'(mismatch_score),
                               int'(gap_penalty), local_mode));
      end
    end
  end

  // Present a cell and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int a, input int b, input int d, input int u, input int l,
                      input int m, input int mm, input int g, input bit loc);
    a_char = CHAR_W'(a);      b_char = CHAR_W'(b);
    score_diag = SCORE_W'(d); score_up = SCORE_W'(u); score_left = SCORE_W'(l);
    match_score = SCORE_W'(m); mismatch_score = SCORE_W'(mm); gap_penalty = SCORE_W'(g);
    local_mode = loc;
    in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", int'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  // Single cell through an empty pipeline with the consumer ready.
  task automatic run_one(input string tag, input int a, input int b, input int d, input int u,
                         input int l, input int m, input int mm, input int g, input bit loc,
                         input int es, input int ed);
    send(a, b, d, u, l, m, mm, g, loc);
    @(negedge clk);
    chk({tag, "_lat1"}, int'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_lat2"}, int'(out_valid), 1);
    chk({tag, "_score"}, int'(score), es);
    chk({tag, "_dir"}, int'(direction), ed);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_score", int'(score), 0);
    chk("post_rst_dir", int'(direction), 0);
    chk("post_rst_best", int'(best_score), S_MIN);
    chk("post_rst_idx", int'(best_idx), 0);
    @(posedge clk);
    #1;

    // Directed scoring cases
    run_one("diag_win", 1, 1, 2, 1, 0, 2, -1, -2, 0, 4, 0);
    run_one("tie_du", 0, 1, 1, 2, -3, 2, -1, -2, 0, 0, 0);
    run_one("tie_up", 0, 1, 0, 2, -3, 2, -1, -2, 0, 0, 1);
    run_one("local_clamp", 0, 1, -3, -1, -2, 2, -1, -2, 1, 0, 3);
    run_one("global_neg", 0, 1, -3, -1, -2, 2, -1, -2, 0, -3, 1);
    run_one("sat_hi", 2, 2, 127, 0, 0, 2, -1, -2, 0, 127, 0);
    run_one("sat_lo", 0, 1, -128, -128, -128, 2, -1, -2, 0, -128, 0);

    // Backpressure: two accepts fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    send(1, 1, 10, 0, 0, 1, -1, -2, 0);
    send(1, 1, 20, 0, 0, 1, -1, -2, 0);
    in_valid = 1'b1;
    score_diag = 8'sd30;
    @(negedge clk);
    chk("bp_ready_low1", int'(in_ready), 0);
    @(negedge clk);
    chk("bp_ready_low2", int'(in_ready), 0);
    chk("bp_out_held", int'(out_valid), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1, 1, 30, 0, 0, 1, -1, -2, 0);
    send(1, 1, 40, 0, 0, 1, -1, -2, 0);
    send(1, 1, 50, 0, 0, 1, -1, -2, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", q.size(), 0);

    // Tracker: clear, then scores 3, 7, 7, 5
    best_clear = 1'b1;
    @(posedge clk);
    #1;
    best_clear = 1'b0;
    send(1, 1, 3, -128, -128, 0, 0, -2, 0);
    send(1, 1, 7, -128, -128, 0, 0, -2, 0);
    send(1, 1, 7, -128, -128, 0, 0, -2, 0);
    send(1, 1, 5, -128, -128, 0, 0, -2, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("trk_best", int'(best_score), 7);
    chk("trk_idx", int'(best_idx), 1);
    @(posedge clk);
    #1;

    // Clear coinciding with a transfer of -4
    out_ready = 1'b0;
    send(1, 1, -4, -128, -128, 0, 0, -2, 0);
    for (int t = 0; t < 8 && !out_valid; t++) @(negedge clk);
    chk("clr_xfer_ready", int'(out_valid), 1);
    @(posedge clk);
    #1;
    best_clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    best_clear = 1'b0;
    @(negedge clk);
    chk("clr_xfer_best", int'(best_score), -4);
    chk("clr_xfer_idx", int'(best_idx), 0);
    @(posedge clk);
    #1;

    // Reset with two cells in flight
    out_ready = 1'b0;
    send(1, 1, 60, 0, 0, 1, -1, -2, 0);
    send(1, 1, 61, 0, 0, 1, -1, -2, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_dir", int'(direction), 0);
    chk("mid_rst_best", int'(best_score), S_MIN);
    chk("mid_rst_idx", int'(best_idx), 0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("mid_rst_no_out", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and occasional clears
    for (int c = 0; c < 600; c++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      a_char         = CHAR_W'($urandom);
      b_char         = CHAR_W'($urandom);
      score_diag     = SCORE_W'($urandom);
      score_up       = SCORE_W'($urandom);
      score_left     = SCORE_W'($urandom);
      match_score    = SCORE_W'($urandom_range(0, 8));
      mismatch_score = SCORE_W'(-$urandom_range(0, 8));
      gap_penalty    = ($urandom_range(0, 7) == 0) ? SCORE_W'($urandom) : SCORE_W'(-$urandom_range(0, 6));
      local_mode     = $urandom_range(0, 1);
      out_ready      = ($urandom_range(0, 3) != 0);
      best_clear     = ($urandom_range(0, 60) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    best_clear = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
